// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: syncs pll_lock, sequences PLL reset and holds
// system reset until lock has been stable for STABLE_CYCLES.
module pll_lock_sequencer #(
   parameter int unsigned RST_PULSE     = 16,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             restart,
   output logic             pll_rst_req,
   output logic             sys_rst_n,
   output logic             clk_ok,
   output logic [CNT_W-1:0] retry_cnt,
   output logic [CNT_W-1:0] loss_cnt
);

   localparam int unsigned MAX_A =
      (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
   localparam int unsigned MAX_T =
      (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int TW = $clog2(MAX_T + 1);

   localparam logic [TW-1:0] PULSE_END  = TW'(RST_PULSE - 1);
   localparam logic [TW-1:0] TMO_END    = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_END = TW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            lock_m, lock_s;
   logic            retry_inc, loss_inc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + TW'(1);
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == PULSE_END)
               state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
            end else if (cnt_q == TMO_END) begin
               state_d   = PLL_RST;
               retry_inc = 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s)
               state_d = WAIT_LOCK;
            else if (cnt_q == STABLE_END)
               state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q;
            if (!lock_s) begin
               state_d  = WAIT_LOCK;
               loss_inc = 1'b1;
            end
         end
         default: state_d = PLL_RST;
      endcase
      // restart overrides any transition and suppresses its count
      if (restart) begin
         state_d   = PLL_RST;
         retry_inc = 1'b0;
         loss_inc  = 1'b0;
      end
      if (restart || (state_d != state_q))
         cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= PLL_RST;
         cnt_q       <= '0;
         retry_cnt   <= '0;
         loss_cnt    <= '0;
         pll_rst_req <= 1'b1;
         sys_rst_n   <= 1'b0;
         clk_ok      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pll_rst_req <= (state_d == PLL_RST);
         sys_rst_n   <= (state_d == RUN);
         clk_ok      <= (state_d == RUN);
         if (retry_inc && (retry_cnt != '1))
            retry_cnt <= retry_cnt + CNT_W'(1);
         if (loss_inc && (loss_cnt != '1))
            loss_cnt <= loss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: vector table for bring-up and lock loss,
// hand sequences for glitch, restart, timeout and saturation.
module tb_pll_lock_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       restart;
   logic       pll_rst_req;
   logic       sys_rst_n;
   logic       clk_ok;
   logic [3:0] retry_cnt;
   logic [3:0] loss_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   typedef struct {
      logic       rst_n;
      logic       lock;
      logic       restart;
      int         n;
      logic       req;
      logic       sys;
      logic       ok;
      logic [3:0] retry;
      logic [3:0] loss;
   } vec_t;

   typedef struct {
      logic       req;
      logic       sys;
      logic       ok;
      logic [3:0] retry;
      logic [3:0] loss;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[9];

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .RST_PULSE    (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .CNT_W        (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_lock   (pll_lock),
      .restart    (restart),
      .pll_rst_req(pll_rst_req),
      .sys_rst_n  (sys_rst_n),
      .clk_ok     (clk_ok),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s cycle %0d: got %0d expected %0d",
                  nm, cyc, act, exp);
   endtask

   task automatic run(input logic r, input logic l, input logic s,
                      input int n, input logic req, input logic sys,
                      input logic ok, input logic [3:0] rc,
                      input logic [3:0] lc);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         rst_n    = r;
         pll_lock = l;
         restart  = s;
         sb.push_back('{req, sys, ok, rc, lc});
         @(posedge clk);
         #1;
         cyc++;
         e = sb.pop_front();
         chk("pll_rst_req", {7'd0, pll_rst_req}, {7'd0, e.req});
         chk("sys_rst_n", {7'd0, sys_rst_n}, {7'd0, e.sys});
         chk("clk_ok", {7'd0, clk_ok}, {7'd0, e.ok});
         chk("retry_cnt", {4'd0, retry_cnt}, {4'd0, e.retry});
         chk("loss_cnt", {4'd0, loss_cnt}, {4'd0, e.loss});
      end
   endtask

   initial begin
      logic [3:0] r;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      restart  = 1'b0;

      // bring-up: 4-cycle reset pulse, lock 2 cycles later, RUN 11 later
      tbl[0] = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0};
      // one-cycle lock drop in RUN
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 9,  1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b1, 4'd0, 4'd1};

      for (int i = 0; i < 9; i++)
         run(tbl[i].rst_n, tbl[i].lock, tbl[i].restart, tbl[i].n,
             tbl[i].req, tbl[i].sys, tbl[i].ok, tbl[i].retry,
             tbl[i].loss);

      // restart in RUN, then glitch at STABLE cycle 5
      run(1, 1, 1, 1,  1, 0, 0, 0, 1);
      run(1, 1, 0, 3,  1, 0, 0, 0, 1);
      run(1, 1, 0, 1,  0, 0, 0, 0, 1);
      run(1, 1, 0, 4,  0, 0, 0, 0, 1);
      run(1, 0, 0, 1,  0, 0, 0, 0, 1);
      run(1, 1, 0, 10, 0, 0, 0, 0, 1);
      run(1, 1, 0, 2,  0, 1, 1, 0, 1);

      // lose lock for good: loss, then repeated timeouts
      run(1, 0, 0, 2,  0, 1, 1, 0, 1);
      run(1, 0, 0, 1,  0, 0, 0, 0, 2);
      run(1, 0, 0, 19, 0, 0, 0, 0, 2);
      for (int i = 1; i <= 17; i++) begin
         r = (i > 15) ? 4'd15 : 4'(i);
         run(1, 0, 0, 4, 1, 0, 0, r, 2);
         if (i == 1) begin
            run(1, 0, 0, 20, 0, 0, 0, 1, 2);
            run(1, 0, 1, 1,  1, 0, 0, 1, 2);
            run(1, 0, 0, 2,  1, 0, 0, 1, 2);
            run(1, 0, 1, 1,  1, 0, 0, 1, 2);
            run(1, 0, 0, 3,  1, 0, 0, 1, 2);
            run(1, 0, 0, 20, 0, 0, 0, 1, 2);
         end else begin
            run(1, 0, 0, 20, 0, 0, 0, r, 2);
         end
      end

      // mid-operation reset clears counters
      run(1, 0, 0, 1, 1, 0, 0, 15, 2);
      run(0, 0, 0, 1, 1, 0, 0, 0, 0);
      run(1, 0, 0, 2, 1, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
